// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the default
// instruction/PC-increment constants used by fetch_ctrl.
package mips_pkg;

  typedef enum logic [2:0] {
    FETCH    = 3'd0,
    PRESENT  = 3'd1,
    ADVANCE  = 3'd2,
    REDIRECT = 3'd3,
    DISCARD  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: keeps at most one instruction-memory request in
// flight, hands the fetched word to decode and strobes the PC forward or to a branch target.
module fetch_ctrl #(
  parameter logic [31:0] NOP     = mips_pkg::NOP,
  parameter logic [31:0] PC_STEP = mips_pkg::PC_STEP
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        MemReady,
  input  logic [31:0] MemRData,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  output logic [31:0] PCNext,
  output logic        PCWrite,
  output logic        PCWriteN,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] FetchCount
);

  mips_pkg::fetch_state_e state_q;
  logic        mem_req_q;
  logic [31:0] hold_addr_q;
  logic [31:0] pc_next_q;
  logic        pc_write_q;
  logic        pc_write_n_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic [31:0] fetch_count_q;

  logic [31:0] pc_seq;
  logic        req_pending;
  logic        branch_discard;

  assign pc_seq = PCResult + PC_STEP;

  // A request is outstanding only while MemReq is up in a memory-facing state;
  // the first cycle after reset has MemReq low, so a stray MemReady is ignored.
  assign req_pending    = mem_req_q &&
                          ((state_q == mips_pkg::FETCH) || (state_q == mips_pkg::DISCARD));
  assign branch_discard = req_pending && !MemReady;

  // While discarding, memory must keep seeing the address it was asked for,
  // even though the PC register has already moved to the branch target.
  assign MemAddr = (state_q == mips_pkg::DISCARD) ? hold_addr_q : PCResult;

  assign MemReq     = mem_req_q;
  assign PCNext     = pc_next_q;
  assign PCWrite    = pc_write_q;
  assign PCWriteN   = pc_write_n_q;
  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign FetchCount = fetch_count_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= mips_pkg::FETCH;
      mem_req_q     <= 1'b0;
      hold_addr_q   <= 32'h0;
      pc_next_q     <= 32'h0;
      pc_write_q    <= 1'b0;
      pc_write_n_q  <= 1'b0;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      pc_write_q   <= 1'b0;
      pc_write_n_q <= 1'b0;
      if (BranchTaken) begin
        pc_next_q     <= BranchTarget;
        pc_write_n_q  <= 1'b1;
        instr_valid_q <= 1'b0;
        instr_q       <= NOP;
        if (branch_discard) begin
          state_q     <= mips_pkg::DISCARD;
          mem_req_q   <= 1'b1;
          hold_addr_q <= MemAddr;
        end else begin
          state_q   <= mips_pkg::REDIRECT;
          mem_req_q <= 1'b0;
        end
      end else begin
        case (state_q)
          mips_pkg::FETCH: begin
            if (!mem_req_q) begin
              mem_req_q <= 1'b1;
            end else if (MemReady) begin
              instr_q       <= MemRData;
              instr_valid_q <= 1'b1;
              mem_req_q     <= 1'b0;
              state_q       <= mips_pkg::PRESENT;
            end
          end
          mips_pkg::PRESENT: begin
            if (!Stall) begin
              fetch_count_q <= fetch_count_q + 32'd1;
              instr_valid_q <= 1'b0;
              instr_q       <= NOP;
              pc_next_q     <= pc_seq;
              pc_write_q    <= 1'b1;
              state_q       <= mips_pkg::ADVANCE;
            end
          end
          mips_pkg::ADVANCE: begin
            mem_req_q <= 1'b1;
            state_q   <= mips_pkg::FETCH;
          end
          mips_pkg::REDIRECT: begin
            mem_req_q <= 1'b1;
            state_q   <= mips_pkg::FETCH;
          end
          mips_pkg::DISCARD: begin
            // The stale word is dropped; MemReq stays up for the new PC.
            if (MemReady) begin
              state_q <= mips_pkg::FETCH;
            end
          end
          default: begin
            mem_req_q <= 1'b0;
            state_q   <= mips_pkg::FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and instruction memory around the DUT,
// an architectural-PC reference model feeding expectation queues, and a monitor.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP_V  = 32'h0000_0000;
  localparam logic [31:0] STEP_V = 32'd4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] PCResult;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        MemReady = 1'b0;
  logic [31:0] MemRData = 32'h0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] PCNext;
  logic        PCWrite;
  logic        PCWriteN;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] FetchCount;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcnext;
    logic [31:0] count;
  } cons_t;

  cons_t       cons_q[$];
  logic [31:0] redir_q[$];
  logic [31:0] ref_pc = 32'h0;
  logic [31:0] ref_count = 32'h0;

  int lat_min = 2;
  int lat_max = 2;
  bit mem_force = 1'b0;

  always #5 Clk = ~Clk;

  fetch_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCResult     (PCResult),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .MemReady     (MemReady),
    .MemRData     (MemRData),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .PCNext       (PCNext),
    .PCWrite      (PCWrite),
    .PCWriteN     (PCWriteN),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .FetchCount   (FetchCount)
  );

  // Program counter register loaded by either strobe.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) PCResult <= 32'h0;
    else if (PCWrite || PCWriteN) PCResult <= PCNext;
  end

  // Instruction memory contents: a bijective scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers a held request after a latency, with data for the current address.
  initial begin : memory_model
    int  wait_cnt;
    bit  have_lat;
    wait_cnt = 0;
    have_lat = 1'b0;
    forever begin
      @(negedge Clk);
      #1;
      MemReady = 1'b0;
      if (mem_force) begin
        MemReady = 1'b1;
        MemRData = 32'hDEAD_BEEF;
      end else if (MemReq && Reset) begin
        if (!have_lat) begin
          wait_cnt = $urandom_range(lat_max, lat_min);
          have_lat = 1'b1;
        end
        if (wait_cnt == 0) begin
          MemReady = 1'b1;
          MemRData = memf(MemAddr);
          have_lat = 1'b0;
        end else begin
          wait_cnt--;
        end
      end else begin
        have_lat = 1'b0;
      end
    end
  end

  // Monitor: compares DUT handoffs and PC strobes against queued expectations.
  initial begin : monitor
    cons_t       e;
    logic [31:0] t;
    forever begin
      @(negedge Clk);
      #2;
      if (Reset) begin
        if (PCWrite || PCWriteN) check("strobe_exclusive", {31'h0, PCWrite & PCWriteN}, 32'h0);
        if (InstrValid && !Stall && !BranchTaken) begin
          if (cons_q.size() == 0) check("consume_expected", 32'h0, 32'h1);
          else check("instr", Instr, cons_q[0].instr);
        end
        if (PCWrite) begin
          if (cons_q.size() == 0) begin
            check("pcwrite_expected", 32'h0, 32'h1);
          end else begin
            e = cons_q.pop_front();
            check("pcnext_seq", PCNext, e.pcnext);
            check("fetch_count", FetchCount, e.count);
            $display("txn consume #%0d instr=%h pcnext=%h", e.count, e.instr, e.pcnext);
          end
        end
        if (PCWriteN) begin
          if (redir_q.size() == 0) begin
            check("pcwriten_expected", 32'h0, 32'h1);
          end else begin
            t = redir_q.pop_front();
            check("pcnext_redirect", PCNext, t);
            $display("txn redirect target=%h", t);
          end
        end
      end
    end
  end

  // One cycle of stimulus, driven on the falling edge; updates the reference model.
  task automatic step(input bit s, input bit b, input logic [31:0] t);
    @(negedge Clk);
    Stall        = s;
    BranchTaken  = b;
    BranchTarget = b ? t : 32'h0BAD_0000;
    if (Reset) begin
      if (b) begin
        ref_pc = t;
        redir_q.push_back(t);
      end else if (InstrValid && !s) begin
        ref_count = ref_count + 32'd1;
        cons_q.push_back('{instr: memf(ref_pc), pcnext: ref_pc + STEP_V, count: ref_count});
        ref_pc = ref_pc + STEP_V;
      end
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 32'h0);
      #3;
      if (InstrValid) break;
    end
    check(name, {31'h0, InstrValid}, 32'h1);
  endtask

  initial begin : stimulus
    bit          s;
    bit          b;
    bit          got;
    logic [31:0] t;

    #1 Reset = 1'b0;
    #1;
    check("rst_memreq",   {31'h0, MemReq},     32'h0);
    check("rst_pcwrite",  {31'h0, PCWrite},    32'h0);
    check("rst_pcwriten", {31'h0, PCWriteN},   32'h0);
    check("rst_pcnext",   PCNext,              32'h0);
    check("rst_instr",    Instr,               NOP_V);
    check("rst_valid",    {31'h0, InstrValid}, 32'h0);
    check("rst_count",    FetchCount,          32'h0);

    // Release with a spurious MemReady in the first cycle; it must be ignored.
    @(negedge Clk);
    Reset = 1'b1;
    mem_force = 1'b1;
    #3 check("rel_memreq_low", {31'h0, MemReq}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    mem_force = 1'b0;
    #3;
    check("rel_memreq_high", {31'h0, MemReq}, 32'h1);
    check("rel_addr0", MemAddr, 32'h0);
    check("rel_no_valid", {31'h0, InstrValid}, 32'h0);

    // Basic fetch, no stall.
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b0, 1'b0, 32'h0);
      #3 got = MemReady;
    end
    check("first_ready_seen", {31'h0, got}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    #3;
    check("first_valid", {31'h0, InstrValid}, 32'h1);
    check("first_instr", Instr, memf(32'h0));
    step(1'b0, 1'b0, 32'h0);
    #3;
    check("first_pcwrite", {31'h0, PCWrite}, 32'h1);
    check("first_pcnext", PCNext, 32'h4);
    check("first_count", FetchCount, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    #3;
    check("refetch_req", {31'h0, MemReq}, 32'h1);
    check("refetch_addr", MemAddr, 32'h4);

    // Three stalled cycles then accept.
    wait_valid("stall_valid");
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0);
      #3;
      check("stall_hold_valid", {31'h0, InstrValid}, 32'h1);
      check("stall_no_pcwrite", {31'h0, PCWrite}, 32'h0);
    end
    step(1'b0, 1'b0, 32'h0);
    #3 check("stall_release_valid", {31'h0, InstrValid}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    #3;
    check("stall_pcwrite", {31'h0, PCWrite}, 32'h1);
    check("stall_count", FetchCount, 32'h2);

    // Branch while a request is pending: stale word dropped.
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 32'h0);
    #3;
    check("br_pending_pcwriten", {31'h0, PCWriteN}, 32'h1);
    check("br_pending_pcnext", PCNext, 32'h40);
    check("br_pending_held_addr", MemAddr, 32'h8);
    check("br_pending_memreq", {31'h0, MemReq}, 32'h1);
    wait_valid("br_target_valid");
    check("br_target_instr", Instr, memf(32'h40));
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // PC wrap at the top of the address space, then a branch during ADVANCE.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_valid("wrap_valid");
    check("wrap_instr", Instr, memf(32'hFFFF_FFFC));
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    #3;
    check("adv_pcwrite", {31'h0, PCWrite}, 32'h1);
    check("adv_pcnext_wrap", PCNext, 32'h0);
    check("adv_no_pcwriten", {31'h0, PCWriteN}, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    #3;
    check("adv_then_pcwriten", {31'h0, PCWriteN}, 32'h1);
    check("adv_then_no_pcwrite", {31'h0, PCWrite}, 32'h0);
    check("adv_then_pcnext", PCNext, 32'h100);
    wait_valid("adv_target_valid");
    check("adv_target_instr", Instr, memf(32'h100));

    // Asynchronous reset while presenting an instruction.
    check("queues_idle", cons_q.size() + redir_q.size(), 32'h0);
    #1 Reset = 1'b0;
    #1;
    check("async_valid", {31'h0, InstrValid}, 32'h0);
    check("async_instr", Instr, NOP_V);
    check("async_count", FetchCount, 32'h0);
    check("async_memreq", {31'h0, MemReq}, 32'h0);
    cons_q.delete();
    redir_q.delete();
    ref_pc = 32'h0;
    ref_count = 32'h0;
    @(negedge Clk);
    Reset = 1'b1;

    // Randomized traffic.
    lat_min = 0;
    lat_max = 4;
    for (int c = 0; c < 3000; c++) begin
      s = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(s, b, t);
    end
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 32'h0);
    #3;
    check("drain_cons_q", cons_q.size(), 32'h0);
    check("drain_redir_q", redir_q.size(), 32'h0);
    check("final_count", FetchCount, ref_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
